// File: rtl/pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_pkg
// Description : Shared game-state encoding and default playfield geometry
//               for the scrolling pipe generator.
// Revision    : 1.0 - initial release
// ============================================================================
package pipe_pkg;

  // Default playfield geometry and pacing
  localparam int C_COLS     = 16;
  localparam int C_ROWS     = 16;
  localparam int C_GAP      = 4;
  localparam int C_SPACING  = 6;
  localparam int C_BIRD_COL = 3;

  // Game state, explicitly 2-bit encoded
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_FROZEN = 2'd2
  } state_t;

endpackage : pipe_pkg
`default_nettype wire

// File: rtl/pipe_generator_gap_mapper.sv
`default_nettype none
// ============================================================================
// Module      : gap_mapper
// Description : Folds a 4-bit random nibble onto a legal gap top row so the
//               gap never touches row 0 or the bottom row.
// Revision    : 1.0 - initial release
// ============================================================================
module gap_mapper #(
  parameter int ROWS = 16,
  parameter int GAP  = 4
) (
  input  logic [3:0] i_rnd_nib,
  output logic [3:0] o_gap_top
);

  localparam int MAX_TOP = ROWS - GAP - 1;

  // 0 would expose row 0, values above MAX_TOP would reach the bottom row;
  // both are folded back into the legal window.
  always_comb begin
    o_gap_top = i_rnd_nib;
    if (i_rnd_nib == 4'd0) begin
      o_gap_top = 4'd1;
    end else if (int'(i_rnd_nib) > MAX_TOP) begin
      o_gap_top = i_rnd_nib - 4'd8;
    end
  end

endmodule : gap_mapper
`default_nettype wire

// File: rtl/pipe_generator.sv
`default_nettype none
// ============================================================================
// Module      : pipe_generator
// Description : Scrolls a pipe playfield one column left per Tick, spawning a
//               pipe column with a random gap every SPACING ticks and pulsing
//               Pass when a pipe reaches the bird column.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_generator
  import pipe_pkg::*;
#(
  parameter int COLS     = C_COLS,
  parameter int ROWS     = C_ROWS,
  parameter int GAP      = C_GAP,
  parameter int SPACING  = C_SPACING,
  parameter int BIRD_COL = C_BIRD_COL
) (
  input  logic                       Clock,
  input  logic                       Reset,
  input  logic                       Start,
  input  logic                       Stop,
  input  logic                       Tick,
  input  logic [15:0]                Rnd,
  output logic [ROWS-1:0][COLS-1:0]  Grid,
  output logic                       Running,
  output logic                       Pass,
  output logic [3:0]                 GapTop
);

  localparam int CNT_W = (SPACING > 1) ? $clog2(SPACING) : 1;

  state_t                      r_state;
  state_t                      w_state_nxt;
  logic [ROWS-1:0][COLS-1:0]   r_grid;
  logic [ROWS-1:0][COLS-1:0]   w_grid_nxt;
  logic [CNT_W-1:0]            r_cnt;
  logic [3:0]                  r_gap_top;
  logic                        r_pass;
  logic [3:0]                  w_gap_top;
  logic                        w_shift;
  logic                        w_spawn;
  logic                        w_clear;
  logic                        w_bird_hit;
  logic                        w_rnd_unused;

  // Only the low nibble of the LFSR word drives the gap position
  assign w_rnd_unused = ^Rnd[15:4];

  gap_mapper #(
    .ROWS (ROWS),
    .GAP  (GAP)
  ) u_gap_mapper (
    .i_rnd_nib (Rnd[3:0]),
    .o_gap_top (w_gap_top)
  );

  // Stop has priority over Tick, so a collision cycle never scrolls
  assign w_shift = (r_state == ST_RUN) && !Stop && Tick;
  assign w_spawn = (r_cnt == CNT_W'(SPACING - 1));
  assign w_clear = (r_state != ST_RUN) && Start;

  // State register
  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:   if (Start) w_state_nxt = ST_RUN;
      ST_RUN:    if (Stop)  w_state_nxt = ST_FROZEN;
      ST_FROZEN: if (Start) w_state_nxt = ST_RUN;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  // State-derived outputs
  always_comb begin
    Running = (r_state == ST_RUN);
  end

  // Shifted playfield with the incoming right-hand column appended
  always_comb begin
    w_grid_nxt = '0;
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS - 1; c++) begin
        w_grid_nxt[r][c] = r_grid[r][c + 1];
      end
      w_grid_nxt[r][COLS - 1] = w_spawn &&
          !((r >= int'(w_gap_top)) && (r < int'(w_gap_top) + GAP));
    end
  end

  // A pipe column always has solid rows, so any set bit marks its arrival
  always_comb begin
    w_bird_hit = 1'b0;
    for (int r = 0; r < ROWS; r++) begin
      w_bird_hit = w_bird_hit | w_grid_nxt[r][BIRD_COL];
    end
  end

  // Playfield, spawn pacing, gap register and score pulse
  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_grid    <= '0;
      r_cnt     <= '0;
      r_gap_top <= '0;
      r_pass    <= 1'b0;
    end else begin
      r_pass <= 1'b0;
      if (w_clear) begin
        r_grid <= '0;
        r_cnt  <= '0;
      end else if (w_shift) begin
        r_grid <= w_grid_nxt;
        r_pass <= w_bird_hit;
        if (w_spawn) begin
          r_cnt     <= '0;
          r_gap_top <= w_gap_top;
        end else begin
          r_cnt <= r_cnt + CNT_W'(1);
        end
      end
    end
  end

  assign Grid   = r_grid;
  assign Pass   = r_pass;
  assign GapTop = r_gap_top;

endmodule : pipe_generator
`default_nettype wire

// File: tb/tb_pipe_generator.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_generator
// Description : Directed self-checking bench for pipe_generator at default
//               parameters (16x16 field, gap 4, spacing 6, bird column 3).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_generator;

  logic                Clock = 1'b0;
  logic                Reset = 1'b1;
  logic                Start = 1'b0;
  logic                Stop  = 1'b0;
  logic                Tick  = 1'b0;
  logic [15:0]         Rnd   = 16'h0;
  logic [15:0][15:0]   Grid;
  logic                Running;
  logic                Pass;
  logic [3:0]          GapTop;

  int errors = 0;
  int checks = 0;

  // Pipe column masks (bit r = row r), gap rows cleared
  localparam logic [15:0] COL_GAP1  = 16'hFFE1;
  localparam logic [15:0] COL_GAP4  = 16'hFF0F;
  localparam logic [15:0] COL_GAP5  = 16'hFE1F;
  localparam logic [15:0] COL_GAP7  = 16'hF87F;
  localparam logic [15:0] COL_GAP11 = 16'h87FF;

  logic [15:0][15:0] exp_grid;

  pipe_generator dut (
    .Clock   (Clock),
    .Reset   (Reset),
    .Start   (Start),
    .Stop    (Stop),
    .Tick    (Tick),
    .Rnd     (Rnd),
    .Grid    (Grid),
    .Running (Running),
    .Pass    (Pass),
    .GapTop  (GapTop)
  );

  always #5 Clock = ~Clock;

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [15:0][15:0] put_col(input logic [15:0][15:0] g,
                                                 input int c,
                                                 input logic [15:0] col);
    logic [15:0][15:0] t;
    t = g;
    for (int r = 0; r < 16; r++) t[r][c] = col[r];
    return t;
  endfunction

  task automatic chk(input string tag, input logic [255:0] obs,
                     input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock edge, then settle before sampling
  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  task automatic tick(input logic [15:0] rnd);
    Rnd  = rnd;
    Tick = 1'b1;
    step();
    Tick = 1'b0;
  endtask

  task automatic start_pulse();
    Start = 1'b1;
    step();
    Start = 1'b0;
  endtask

  initial begin
    // Reset with other inputs active
    Start = 1'b1; Tick = 1'b1;
    step(); step();
    chk("reset_grid",    256'(Grid),    256'(0));
    chk("reset_running", 256'(Running), 256'(0));
    chk("reset_pass",    256'(Pass),    256'(0));
    chk("reset_gaptop",  256'(GapTop),  256'(0));
    Start = 1'b0; Tick = 1'b0;
    Reset = 1'b0;
    step();

    // Tick in IDLE is ignored
    tick(16'h0005);
    chk("idle_tick_grid",    256'(Grid),    256'(0));
    chk("idle_tick_running", 256'(Running), 256'(0));

    start_pulse();
    chk("start_running", 256'(Running), 256'(1));
    chk("start_grid",    256'(Grid),    256'(0));

    // Spacing: five empty columns, then the pipe on the sixth Tick
    for (int i = 0; i < 5; i++) tick(16'h0005);
    chk("spacing_empty", 256'(Grid), 256'(0));
    tick(16'h0005);
    exp_grid = put_col('0, 15, COL_GAP5);
    chk("spacing_pipe",   256'(Grid),   256'(exp_grid));
    chk("spacing_gaptop", 256'(GapTop), 256'(5));

    // Start in RUN is ignored
    start_pulse();
    chk("run_start_grid", 256'(Grid), 256'(exp_grid));

    // Scoring run: ticks 7..12 with nibble 0, 13..18 with nibble B
    for (int i = 0; i < 11; i++) begin
      tick((i < 6) ? 16'hFFF0 : 16'h000B);
      chk("no_pass_early", 256'(Pass), 256'(0));
      if (i == 5) chk("gap_map_0", 256'(GapTop), 256'(1));
    end
    tick(16'h000B);
    exp_grid = put_col('0, 3, COL_GAP5);
    exp_grid = put_col(exp_grid, 9, COL_GAP1);
    exp_grid = put_col(exp_grid, 15, COL_GAP11);
    chk("score_pass",   256'(Pass),   256'(1));
    chk("score_grid",   256'(Grid),   256'(exp_grid));
    chk("gap_map_B",    256'(GapTop), 256'(11));
    step();
    chk("pass_one_cycle", 256'(Pass), 256'(0));

    // Remaining gap-mapping cases
    for (int i = 0; i < 6; i++) tick(16'h123C);
    chk("gap_map_C", 256'(GapTop), 256'(4));
    for (int i = 0; i < 6; i++) tick(16'hABCF);
    chk("gap_map_F", 256'(GapTop), 256'(7));

    // Freeze: Stop beats a simultaneous Tick
    exp_grid = put_col('0, 3, COL_GAP11);
    exp_grid = put_col(exp_grid, 9, COL_GAP4);
    exp_grid = put_col(exp_grid, 15, COL_GAP7);
    chk("pre_freeze_grid", 256'(Grid), 256'(exp_grid));
    Stop = 1'b1; Tick = 1'b1;
    step();
    Stop = 1'b0; Tick = 1'b0;
    chk("freeze_grid",    256'(Grid),    256'(exp_grid));
    chk("freeze_running", 256'(Running), 256'(0));
    chk("freeze_pass",    256'(Pass),    256'(0));
    tick(16'h0005); tick(16'h0005);
    chk("frozen_tick_grid", 256'(Grid), 256'(exp_grid));
    start_pulse();
    chk("restart_running", 256'(Running), 256'(1));
    chk("restart_grid",    256'(Grid),    256'(0));

    // Reset mid-game with two pipes on screen
    for (int i = 0; i < 12; i++) tick(16'h0005);
    exp_grid = put_col('0, 9, COL_GAP5);
    exp_grid = put_col(exp_grid, 15, COL_GAP5);
    chk("two_pipes_grid", 256'(Grid), 256'(exp_grid));
    Reset = 1'b1; Start = 1'b1; Tick = 1'b1;
    step();
    Reset = 1'b0; Start = 1'b0; Tick = 1'b0;
    chk("midreset_grid",    256'(Grid),    256'(0));
    chk("midreset_running", 256'(Running), 256'(0));
    chk("midreset_pass",    256'(Pass),    256'(0));
    chk("midreset_gaptop",  256'(GapTop),  256'(0));
    start_pulse();
    chk("post_reset_start", 256'(Running), 256'(1));
    for (int i = 0; i < 5; i++) tick(16'h0005);
    chk("post_reset_empty", 256'(Grid), 256'(0));
    tick(16'h0005);
    chk("post_reset_pipe", 256'(Grid), 256'(put_col('0, 15, COL_GAP5)));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_pipe_generator
`default_nettype wire

// File: doc/pipe_generator.md
PIPE_GENERATOR -- requirements
Module: pipe_generator

Interface
REQ-001 Parameters SHALL be: COLS, default 16, playfield columns; ROWS, default 16, playfield rows; GAP, default 4, gap height in rows; SPACING, default 6, ticks between pipe spawns; BIRD_COL, default 3, scoring column.
REQ-002 Port Clock, in, 1: clock; all logic SHALL be on its rising edge.
REQ-003 Port Reset, in, 1: reset, synchronous, active-high.
REQ-004 Port Start, in, 1: level-sampled start/restart request.
REQ-005 Port Stop, in, 1: freeze request (collision).
REQ-006 Port Tick, in, 1: one-cycle scroll strobe.
REQ-007 Port Rnd, in, 16: pseudo-random word from the upstream 16-bit LFSR; only Rnd[3:0] is used.
REQ-008 Port Grid, out, ROWS x COLS: Grid[r][c]=1 marks a pipe pixel; column 0 is leftmost.
REQ-009 Port Running, out, 1: high in state RUN.
REQ-010 Port Pass, out, 1: one-cycle score pulse.
REQ-011 Port GapTop, out, 4: top row of the most recently spawned gap.

Function
REQ-012 States SHALL be IDLE, RUN and FROZEN, held in a registered state variable.
REQ-013 IDLE: Start=1 -> RUN; clear Grid; clear the spawn counter.
REQ-014 RUN: Stop=1 -> FROZEN; Stop SHALL win over a simultaneous Tick, so no shift occurs in that cycle.
REQ-015 FROZEN: Grid is held; Start=1 -> RUN, with Grid and the spawn counter cleared in the same edge.
REQ-016 Start in RUN, and Tick in IDLE or FROZEN, SHALL be ignored.
REQ-017 On each Tick in RUN (Stop=0), every column c SHALL take the value of column c+1; column 0 contents are discarded.
REQ-018 On that same Tick, column COLS-1 SHALL be loaded as follows:
  - if spawn counter = SPACING-1: a pipe column, with every row set except rows GapTop'..GapTop'+GAP-1; the counter returns to 0.
  - otherwise: an empty column; the counter increments by 1.
REQ-019 GapTop' SHALL be computed combinationally from Rnd[3:0] in the Tick cycle; with v = Rnd[3:0] and MAX_TOP = ROWS-GAP-1 (11 at defaults):
  - v = 0 -> 1
  - v > MAX_TOP -> v-8
  - otherwise -> v
REQ-020 GapTop SHALL register GapTop' only on spawning Ticks.
REQ-021 The gap SHALL never include row 0 or row ROWS-1 at default parameters.
REQ-022 Grid, Pass and GapTop SHALL update exactly one clock after the qualifying Tick edge, i.e. registered outputs with latency 1.
REQ-023 Pass SHALL be high for exactly the cycle following a shift that places a pipe column into column BIRD_COL; otherwise Pass is 0.
REQ-024 The spawn counter SHALL be ceil(log2(SPACING)) bits wide and SHALL never exceed SPACING-1.
REQ-025 Back-to-back Ticks on consecutive cycles SHALL each produce one shift.

Reset
REQ-026 While Reset=1, the following SHALL hold at the next edge regardless of other inputs: state=IDLE, Grid=0, spawn counter=0, GapTop=0, Pass=0, Running=0.
REQ-027 Reset asserted mid-RUN SHALL abort the game with no residual pipes.
REQ-028 The first Start after Reset deassertion SHALL be honoured.

Structure
REQ-029 Package pipe_pkg SHALL hold the state enum and the default constants for COLS, ROWS, GAP, SPACING and BIRD_COL.
REQ-030 Sub-module gap_mapper SHALL implement REQ-019 as combinational logic (Rnd[3:0] -> GapTop').
REQ-031 The LFSR SHALL remain external and connect only via Rnd.

Verification
REQ-032 Spacing: Reset, Start, then 6 Ticks with Rnd=0x0005 -> after the 6th Tick, column 15 = pipe with rows 5-8 clear, columns 0-14 empty, GapTop=5.
REQ-033 Gap mapping: Rnd[3:0]=0x0 -> GapTop=1; 0xB -> 11; 0xC -> 4; 0xF -> 7; each checked on a spawning Tick.
REQ-034 Scoring: continue from REQ-032 with 12 more Ticks -> the pipe reaches column 3, and Pass=1 for exactly one cycle after the 12th Tick.
REQ-035 Freeze: Stop and Tick asserted in the same cycle in RUN -> Grid unchanged, state FROZEN; later Ticks cause no shift; Start -> RUN with Grid=0.
REQ-036 Reset mid-game: Reset asserted with 2 pipes on screen -> next cycle Grid=0, Running=0, Pass=0; a subsequent Start followed by 6 Ticks spawns the first pipe again.
